// File: rtl/main_core_pkg.sv
// rtl/main_core_pkg.sv - shared widths, opcode encodings and operand-select helper for main_core
package main_core_pkg;

    localparam int DATA_W    = 8;
    localparam int OP_W      = 4;
    localparam int NUM_REGS  = 4;
    localparam int MEM_DEPTH = 16;

    typedef enum logic [OP_W-1:0] {
        OP_LD  = 4'b0000,
        OP_ST  = 4'b0001,
        OP_MI  = 4'b0010,
        OP_MR  = 4'b0011,
        OP_SUM = 4'b0100,
        OP_SB  = 4'b0101,
        OP_ANR = 4'b0110,
        OP_CM  = 4'b0111,
        OP_ORR = 4'b1000,
        OP_ORI = 4'b1001,
        OP_XRR = 4'b1010,
        OP_XRI = 4'b1011,
        OP_SMI = 4'b1100,
        OP_SBI = 4'b1101,
        OP_ANI = 4'b1110,
        OP_CMI = 4'b1111
    } opcode_e;

    // ALU ops whose second operand is the immediate rather than R[sel]
    function automatic logic uses_imm(input opcode_e op);
        case (op)
            OP_SMI, OP_SBI, OP_ANI, OP_ORI, OP_XRI, OP_CMI: uses_imm = 1'b1;
            default:                                        uses_imm = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/main_core_if.sv
// rtl/main_core_if.sv - instruction input and accumulator/flag output bundle for main_core
interface main_core_if;
    import main_core_pkg::*;

    logic [OP_W-1:0]   opcode;
    logic [DATA_W-1:0] immediate_input;
    logic [DATA_W-1:0] acc_out;
    logic              zero_flag;
    logic              carry_flag;
    logic              neg_flag;

    modport master (
        output opcode, immediate_input,
        input  acc_out, zero_flag, carry_flag, neg_flag
    );

    modport slave (
        input  opcode, immediate_input,
        output acc_out, zero_flag, carry_flag, neg_flag
    );

endinterface

// File: rtl/main_alu.sv
// rtl/main_alu.sv - combinational 8-bit ALU with carry/borrow output
module main_alu
    import main_core_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  opcode_e           opcode,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    // Widen by one bit so bit 8 is the add carry or the subtract borrow (a < b unsigned)
    always_comb begin
        result = a;
        carry  = 1'b0;
        case (opcode)
            OP_SUM, OP_SMI:
                {carry, result} = {1'b0, a} + {1'b0, b};
            OP_SB, OP_SBI, OP_CM, OP_CMI:
                {carry, result} = {1'b0, a} - {1'b0, b};
            OP_ANR, OP_ANI:
                result = a & b;
            OP_ORR, OP_ORI:
                result = a | b;
            OP_XRR, OP_XRI:
                result = a ^ b;
            default: begin
                result = a;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/main_core.sv
// rtl/main_core.sv - single-cycle accumulator core with register file, data memory and flags
module main_core
    import main_core_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    main_core_if.slave  bus
);

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] mem  [MEM_DEPTH];
    logic              z_q;
    logic              c_q;
    logic              n_q;

    opcode_e           op;
    logic [DATA_W-1:0] imm;
    logic [1:0]        sel;
    logic [3:0]        addr;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic [DATA_W-1:0] acc_next;
    logic              flag_we;

    assign op    = opcode_e'(bus.opcode);
    assign imm   = bus.immediate_input;
    assign sel   = imm[1:0];
    assign addr  = imm[3:0];
    assign alu_b = uses_imm(op) ? imm : regs[sel];

    main_alu u_alu (
        .a      (acc),
        .b      (alu_b),
        .opcode (op),
        .result (alu_result),
        .carry  (alu_carry)
    );

    // Decode: pick the accumulator's next value and whether this op touches the flags
    always_comb begin
        acc_next = acc;
        flag_we  = 1'b0;
        case (op)
            OP_LD:         acc_next = imm;
            OP_MR:         acc_next = mem[addr];
            OP_ST, OP_MI:  acc_next = acc;
            OP_CM, OP_CMI: flag_we  = 1'b1;
            default: begin
                acc_next = alu_result;
                flag_we  = 1'b1;
            end
        endcase
    end

    // Architectural state; every write uses pre-edge acc so MI/ST capture the old value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            z_q <= 1'b0;
            c_q <= 1'b0;
            n_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            for (int j = 0; j < MEM_DEPTH; j++) begin
                mem[j] <= '0;
            end
        end else begin
            acc <= acc_next;
            if (op == OP_ST) begin
                mem[addr] <= acc;
            end
            if (op == OP_MI) begin
                regs[sel] <= acc;
            end
            if (flag_we) begin
                z_q <= (alu_result == '0);
                c_q <= alu_carry;
                n_q <= alu_result[DATA_W-1];
            end
        end
    end

    assign bus.acc_out    = acc;
    assign bus.zero_flag  = z_q;
    assign bus.carry_flag = c_q;
    assign bus.neg_flag   = n_q;

endmodule

// File: tb/tb_main_core.sv
// tb/tb_main_core.sv - directed self-checking bench for main_core
module tb_main_core;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    main_core_if bus_if ();

    main_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one instruction at the falling edge, return 1 time unit after the executing edge
    task automatic exec(input logic [3:0] op, input logic [7:0] imm);
        @(negedge clk);
        bus_if.opcode          = op;
        bus_if.immediate_input = imm;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n                  = 1'b0;
        bus_if.opcode          = 4'b0000;
        bus_if.immediate_input = 8'h77;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus_if.acc_out !== 8'h00) begin errors++; $display("FAIL reset_acc got %h want 00", bus_if.acc_out); end
        checks++; if (bus_if.zero_flag !== 1'b0) begin errors++; $display("FAIL reset_z got %b want 0", bus_if.zero_flag); end
        checks++; if (bus_if.carry_flag !== 1'b0) begin errors++; $display("FAIL reset_c got %b want 0", bus_if.carry_flag); end
        checks++; if (bus_if.neg_flag !== 1'b0) begin errors++; $display("FAIL reset_n got %b want 0", bus_if.neg_flag); end
        @(negedge clk);
        bus_if.opcode          = 4'b0000;
        bus_if.immediate_input = 8'h06;
        rst_n                  = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus_if.acc_out !== 8'h06) begin errors++; $display("FAIL first_ld got %h want 06", bus_if.acc_out); end
    endtask

    task automatic test_add;
        exec(4'b1100, 8'hFE);
        checks++; if (bus_if.acc_out !== 8'h04) begin errors++; $display("FAIL smi_acc got %h want 04", bus_if.acc_out); end
        checks++; if ({bus_if.zero_flag, bus_if.carry_flag, bus_if.neg_flag} !== 3'b010) begin
            errors++; $display("FAIL smi_zcn got %b want 010", {bus_if.zero_flag, bus_if.carry_flag, bus_if.neg_flag}); end
        exec(4'b0000, 8'hFF);
        exec(4'b1100, 8'h01);
        checks++; if (bus_if.acc_out !== 8'h00) begin errors++; $display("FAIL wrap_acc got %h want 00", bus_if.acc_out); end
        checks++; if ({bus_if.zero_flag, bus_if.carry_flag, bus_if.neg_flag} !== 3'b110) begin
            errors++; $display("FAIL wrap_zcn got %b want 110", {bus_if.zero_flag, bus_if.carry_flag, bus_if.neg_flag}); end
    endtask

    task automatic test_cleared_state;
        exec(4'b0000, 8'h11);
        exec(4'b0011, 8'h05);
        checks++; if (bus_if.acc_out !== 8'h00) begin errors++; $display("FAIL mem_reset got %h want 00", bus_if.acc_out); end
        exec(4'b0000, 8'h21);
        exec(4'b0100, 8'h03);
        checks++; if (bus_if.acc_out !== 8'h21) begin errors++; $display("FAIL reg_reset_sum got %h want 21", bus_if.acc_out); end
        checks++; if ({bus_if.zero_flag, bus_if.carry_flag, bus_if.neg_flag} !== 3'b000) begin
            errors++; $display("FAIL reg_reset_zcn got %b want 000", {bus_if.zero_flag, bus_if.carry_flag, bus_if.neg_flag}); end
    endtask

    task automatic test_sub;
        exec(4'b0000, 8'h03);
        exec(4'b1101, 8'h05);
        checks++; if (bus_if.acc_out !== 8'hFE) begin errors++; $display("FAIL sbi_acc got %h want fe", bus_if.acc_out); end
        checks++; if ({bus_if.zero_flag, bus_if.carry_flag, bus_if.neg_flag} !== 3'b011) begin
            errors++; $display("FAIL sbi_zcn got %b want 011", {bus_if.zero_flag, bus_if.carry_flag, bus_if.neg_flag}); end
    endtask

    task automatic test_compare;
        exec(4'b0000, 8'h04);
        exec(4'b1111, 8'h04);
        checks++; if (bus_if.acc_out !== 8'h04) begin errors++; $display("FAIL cmi_acc got %h want 04", bus_if.acc_out); end
        checks++; if ({bus_if.zero_flag, bus_if.carry_flag, bus_if.neg_flag} !== 3'b100) begin
            errors++; $display("FAIL cmi_zcn got %b want 100", {bus_if.zero_flag, bus_if.carry_flag, bus_if.neg_flag}); end
    endtask

    task automatic test_memory;
        exec(4'b0000, 8'hF9);
        exec(4'b0001, 8'h09);
        exec(4'b0000, 8'h00);
        exec(4'b0011, 8'h09);
        checks++; if (bus_if.acc_out !== 8'hF9) begin errors++; $display("FAIL mr_acc got %h want f9", bus_if.acc_out); end
        checks++; if ({bus_if.zero_flag, bus_if.carry_flag, bus_if.neg_flag} !== 3'b100) begin
            errors++; $display("FAIL mr_flags_kept got %b want 100", {bus_if.zero_flag, bus_if.carry_flag, bus_if.neg_flag}); end
        exec(4'b0000, 8'h3C);
        exec(4'b0001, 8'h05);
        exec(4'b0011, 8'h05);
        checks++; if (bus_if.acc_out !== 8'h3C) begin errors++; $display("FAIL st_mr_b2b got %h want 3c", bus_if.acc_out); end
        exec(4'b0011, 8'h09);
        checks++; if (bus_if.acc_out !== 8'hF9) begin errors++; $display("FAIL mr_addr9_kept got %h want f9", bus_if.acc_out); end
    endtask

    task automatic test_regs;
        exec(4'b0000, 8'h00);
        exec(4'b1101, 8'h01);
        checks++; if (bus_if.carry_flag !== 1'b1) begin errors++; $display("FAIL borrow_setup got %b want 1", bus_if.carry_flag); end
        exec(4'b0000, 8'h05);
        exec(4'b0010, 8'h02);
        exec(4'b0000, 8'h03);
        exec(4'b1010, 8'h02);
        checks++; if (bus_if.acc_out !== 8'h06) begin errors++; $display("FAIL xrr_acc got %h want 06", bus_if.acc_out); end
        checks++; if (bus_if.carry_flag !== 1'b0) begin errors++; $display("FAIL xrr_c got %b want 0", bus_if.carry_flag); end
        exec(4'b0110, 8'h02);
        checks++; if (bus_if.acc_out !== 8'h04) begin errors++; $display("FAIL anr_acc got %h want 04", bus_if.acc_out); end
        exec(4'b0111, 8'h02);
        checks++; if (bus_if.acc_out !== 8'h04) begin errors++; $display("FAIL cm_acc got %h want 04", bus_if.acc_out); end
        checks++; if ({bus_if.zero_flag, bus_if.carry_flag, bus_if.neg_flag} !== 3'b011) begin
            errors++; $display("FAIL cm_zcn got %b want 011", {bus_if.zero_flag, bus_if.carry_flag, bus_if.neg_flag}); end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        bus_if.opcode          = 4'b0000;
        bus_if.immediate_input = 8'h55;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus_if.acc_out !== 8'h00) begin errors++; $display("FAIL async_acc got %h want 00", bus_if.acc_out); end
        checks++; if ({bus_if.zero_flag, bus_if.carry_flag, bus_if.neg_flag} !== 3'b000) begin
            errors++; $display("FAIL async_zcn got %b want 000", {bus_if.zero_flag, bus_if.carry_flag, bus_if.neg_flag}); end
        @(posedge clk);
        #1;
        checks++; if (bus_if.acc_out !== 8'h00) begin errors++; $display("FAIL discard_ld got %h want 00", bus_if.acc_out); end
        @(negedge clk);
        bus_if.immediate_input = 8'h2A;
        rst_n                  = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus_if.acc_out !== 8'h2A) begin errors++; $display("FAIL post_reset_ld got %h want 2a", bus_if.acc_out); end
        exec(4'b0100, 8'h02);
        checks++; if (bus_if.acc_out !== 8'h2A) begin errors++; $display("FAIL r2_cleared got %h want 2a", bus_if.acc_out); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add();
        test_cleared_state();
        test_sub();
        test_compare();
        test_memory();
        test_regs();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
